// File: rtl/mux_writeback_seq.sv
// Write-back source selector with byte/half extraction and a registered result.
// Selecting the memory source waits MEM_LAT cycles before capturing read data.
//
// state | meaning
// IDLE  | waiting for start; non-memory results are captured directly from here
// WAIT  | counting down memory latency with the extraction controls held
module mux_writeback_seq #(
    parameter int WIDTH   = 32,
    parameter int NSRC    = 4,
    parameter int MEM_IDX = 1,
    parameter int MEM_LAT = 2,
    localparam int SELW   = $clog2(NSRC),
    localparam int OFFW   = ($clog2(WIDTH / 8) > 1) ? $clog2(WIDTH / 8) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SELW-1:0]       sel,
    input  logic [NSRC*WIDTH-1:0] src_bus,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [OFFW-1:0]       byte_off,
    output logic [WIDTH-1:0]      data_out,
    output logic                  busy,
    output logic                  done
);
    localparam int NBYTE = WIDTH / 8;
    localparam int NHALF = WIDTH / 16;
    localparam int CNTW  = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state;
    logic [CNTW-1:0]  cnt;
    logic [1:0]       l_size;
    logic             l_sign_ext;
    logic [OFFW-1:0]  l_byte_off;
    logic [WIDTH-1:0] src_sel;
    logic [WIDTH-1:0] src_mem;
    logic             mem_sel;

    function automatic logic [WIDTH-1:0] extract(input logic [WIDTH-1:0] w,
                                                 input logic [1:0]       sz,
                                                 input logic             sx,
                                                 input logic [OFFW-1:0]  off);
        int         bi;
        int         hi;
        logic [7:0]  b;
        logic [15:0] h;
        // Offsets past the last lane wrap around rather than reading off the end.
        bi = int'(off) % NBYTE;
        hi = (int'(off) / 2) % NHALF;
        b  = w[8*bi +: 8];
        h  = w[16*hi +: 16];
        case (sz)
            2'b01:   extract = {{(WIDTH-16){sx & h[15]}}, h};
            2'b10:   extract = {{(WIDTH-8){sx & b[7]}}, b};
            default: extract = w;
        endcase
    endfunction

    // Out-of-range selects fall through to zero.
    always_comb begin
        src_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel == SELW'(i)) begin
                src_sel = src_bus[i*WIDTH +: WIDTH];
            end
        end
    end

    assign src_mem = src_bus[MEM_IDX*WIDTH +: WIDTH];
    assign mem_sel = (MEM_LAT != 0) && (sel == SELW'(MEM_IDX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            l_size     <= '0;
            l_sign_ext <= 1'b0;
            l_byte_off <= '0;
            data_out   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mem_sel) begin
                            l_size     <= size;
                            l_sign_ext <= sign_ext;
                            l_byte_off <= byte_off;
                            cnt        <= CNTW'(MEM_LAT);
                            busy       <= 1'b1;
                            state      <= WAIT;
                        end else begin
                            data_out <= extract(src_sel, size, sign_ext, byte_off);
                            done     <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNTW'(1);
                    // Memory data is sampled live on the terminal-count edge.
                    if (cnt == CNTW'(1)) begin
                        data_out <= extract(src_mem, l_size, l_sign_ext, l_byte_off);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
